// File: rtl/regfile_pkg.sv
// Shared defaults and register types for the multi-port register file and its
// scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode-side bus of the register file: read ports, writeback, issue reservation
// and scoreboard status.
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     flush;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits with set/clear/flush priority, combinational busy
// lookups per read port and a registered count of pending registers.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;
  logic [ADDR_W:0]  cnt;
  logic [ADDR_W:0]  cnt_nxt;
  logic             rsv_ok;
  logic             set_new;
  logic             clr_eff;

  // The count tracks only real transitions of a pending bit, so re-reserving a
  // pending register or clearing an idle one leaves it unchanged.
  always_comb begin
    rsv_ok      = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
    set_new     = rsv_ok && !pending[rsv_addr];
    clr_eff     = wr_en && pending[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));
    pending_nxt = pending;
    if (wr_en) pending_nxt[wr_addr] = 1'b0;
    if (rsv_ok) pending_nxt[rsv_addr] = 1'b1;
    cnt_nxt = cnt + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_eff);
    if (flush) begin
      pending_nxt = '0;
      cnt_nxt     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      cnt     <= '0;
    end else begin
      pending <= pending_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign busy_cnt = cnt;

  // A completing write hides the busy bit this cycle unless the same register
  // is being re-reserved by a younger producer.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [ADDR_W-1:0] addr;
    assign addr       = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_busy[i] = pending[addr] &&
                        !(wr_en && (wr_addr == addr) && !(rsv_en && (rsv_addr == wr_addr)));
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write-to-read bypass, optional hardwired
// zero register and a pending-write scoreboard for the hazard unit.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_mp_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_keep;

  assign wr_keep = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else if (wr_keep) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Zero register beats bypass, bypass beats stored contents.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs[addr];
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
      end else if (bus.wr_en && (bus.wr_addr == addr)) begin
        data = bus.wr_data;
      end
    end

    assign bus.rd_data[i*DATA_W +: DATA_W] = data;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .flush    (bus.flush),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (bus.rd_busy),
    .busy_cnt (bus.busy_cnt)
  );

endmodule
